// File: rtl/nv_nvdla_cdma_wt_pkg.sv
// Shared CDMA weight-path definitions: default widths and DMA read-request pd layout.
package nv_nvdla_cdma_wt_pkg;

  localparam int unsigned WT_ADDR_W   = 64;
  localparam int unsigned WT_SIZE_W   = 15;
  localparam int unsigned WT_MAX_OUTS = 128;
  localparam int unsigned WT_CNT_W    = 8;

  // Source id carried in the top bit of the read-request pd
  typedef enum logic {
    SrcWt  = 1'b0,
    SrcWmb = 1'b1
  } wt_src_id_e;

  // pd layout is {src_id, size, addr}, addr in the low bits
  function automatic int unsigned pd_addr_lsb();
    return 0;
  endfunction

  function automatic int unsigned pd_size_lsb(int unsigned addr_w);
    return addr_w;
  endfunction

  function automatic int unsigned pd_id_bit(int unsigned addr_w, int unsigned size_w);
    return addr_w + size_w;
  endfunction

endpackage

// File: rtl/nv_nvdla_cdma_wt_sp_arb.sv
// Two-input strict-priority arbiter, req0 wins; no grant while the consumer is busy.
module nv_nvdla_cdma_wt_sp_arb (
  input  logic req0,
  input  logic req1,
  input  logic gnt_busy,
  output logic gnt0,
  output logic gnt1
);

  // Purely combinational grant so the winner is known in the request cycle
  always_comb begin
    gnt0 = 1'b0;
    gnt1 = 1'b0;
    if (!gnt_busy) begin
      if (req0) begin
        gnt0 = 1'b1;
      end else if (req1) begin
        gnt1 = 1'b1;
      end
    end
  end

endmodule

// File: rtl/nv_nvdla_cdma_wt_dma_req_sel.sv
// CDMA weight DMA request selector: arbitrates the weight and WMB fetch sources onto one
// registered DMA read-request port and tracks in-flight reads per source.
module nv_nvdla_cdma_wt_dma_req_sel
  import nv_nvdla_cdma_wt_pkg::*;
#(
  parameter int unsigned ADDR_W   = WT_ADDR_W,
  parameter int unsigned SIZE_W   = WT_SIZE_W,
  parameter int unsigned MAX_OUTS = WT_MAX_OUTS
) (
  input  logic                     nvdla_core_clk,
  input  logic                     nvdla_core_rst,
  input  logic                     src0_req_valid,
  output logic                     src0_req_ready,
  input  logic [ADDR_W-1:0]        src0_req_addr,
  input  logic [SIZE_W-1:0]        src0_req_size,
  input  logic                     src1_req_valid,
  output logic                     src1_req_ready,
  input  logic [ADDR_W-1:0]        src1_req_addr,
  input  logic [SIZE_W-1:0]        src1_req_size,
  output logic                     dma_rd_req_vld,
  input  logic                     dma_rd_req_rdy,
  output logic [SIZE_W+ADDR_W:0]   dma_rd_req_pd,
  input  logic                     src0_rsp_done,
  input  logic                     src1_rsp_done,
  output logic [WT_CNT_W-1:0]      src0_outs_cnt,
  output logic [WT_CNT_W-1:0]      src1_outs_cnt,
  output logic                     cnt_err
);

  localparam int unsigned AddrLsb = pd_addr_lsb();
  localparam int unsigned SizeLsb = pd_size_lsb(ADDR_W);
  localparam int unsigned IdBit   = pd_id_bit(ADDR_W, SIZE_W);
  localparam logic [WT_CNT_W-1:0] MaxCnt = WT_CNT_W'(MAX_OUTS);

  logic                         req0, req1, busy;
  logic                         arb_gnt0, arb_gnt1;
  logic                         gnt0, gnt1;
  logic                         vld_q;
  logic [SIZE_W+ADDR_W:0]       pd_q, pd_d;
  logic [1:0][WT_CNT_W-1:0]     cnt_q, cnt_d;
  logic [1:0]                   cnt_inc, cnt_dec;
  logic                         err_q, err_d;

  // A source is eligible only while it has room for another in-flight read
  assign req0 = src0_req_valid & (cnt_q[0] < MaxCnt);
  assign req1 = src1_req_valid & (cnt_q[1] < MaxCnt);
  assign busy = vld_q & ~dma_rd_req_rdy;

  nv_nvdla_cdma_wt_sp_arb u_sp_arb (
    .req0     (req0),
    .req1     (req1),
    .gnt_busy (busy),
    .gnt0     (arb_gnt0),
    .gnt1     (arb_gnt1)
  );

  // Readies must stay low while reset is held even if valids are up
  assign gnt0 = arb_gnt0 & ~nvdla_core_rst;
  assign gnt1 = arb_gnt1 & ~nvdla_core_rst;

  assign src0_req_ready = gnt0;
  assign src1_req_ready = gnt1;

  // Build the pd for the winning source
  always_comb begin
    pd_d                        = '0;
    pd_d[IdBit]                 = gnt1 ? SrcWmb : SrcWt;
    pd_d[IdBit-1:SizeLsb]       = gnt1 ? src1_req_size : src0_req_size;
    pd_d[SizeLsb-1:AddrLsb]     = gnt1 ? src1_req_addr : src0_req_addr;
  end

  // Output register: a grant reloads it even in the cycle the old request is taken
  always_ff @(posedge nvdla_core_clk or posedge nvdla_core_rst) begin
    if (nvdla_core_rst) begin
      vld_q <= 1'b0;
      pd_q  <= '0;
    end else if (gnt0 || gnt1) begin
      vld_q <= 1'b1;
      pd_q  <= pd_d;
    end else if (dma_rd_req_rdy) begin
      vld_q <= 1'b0;
    end
  end

  assign dma_rd_req_vld = vld_q;
  assign dma_rd_req_pd  = pd_q;

  assign cnt_inc = {gnt1, gnt0};
  assign cnt_dec = {src1_rsp_done, src0_rsp_done};

  // In-flight counters: saturate at both ends and flag any attempted wrap
  always_comb begin
    cnt_d = cnt_q;
    err_d = err_q;
    for (int i = 0; i < 2; i++) begin
      if (cnt_inc[i] && !cnt_dec[i]) begin
        if (cnt_q[i] >= MaxCnt) begin
          err_d = 1'b1;
        end else begin
          cnt_d[i] = cnt_q[i] + 1'b1;
        end
      end else if (cnt_dec[i] && !cnt_inc[i]) begin
        if (cnt_q[i] == '0) begin
          err_d = 1'b1;
        end else begin
          cnt_d[i] = cnt_q[i] - 1'b1;
        end
      end
    end
  end

  // Counter and sticky error state
  always_ff @(posedge nvdla_core_clk or posedge nvdla_core_rst) begin
    if (nvdla_core_rst) begin
      cnt_q <= '0;
      err_q <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      err_q <= err_d;
    end
  end

  assign src0_outs_cnt = cnt_q[0];
  assign src1_outs_cnt = cnt_q[1];
  assign cnt_err       = err_q;

endmodule

// File: tb/tb_nv_nvdla_cdma_wt_dma_req_sel.sv
// Randomized bench for the CDMA weight DMA request selector against a transaction-level model.
module tb_nv_nvdla_cdma_wt_dma_req_sel;

  localparam int ADDR_W   = 64;
  localparam int SIZE_W   = 15;
  localparam int MAX_OUTS = 128;

  logic                   clk = 1'b0;
  logic                   rst;
  logic                   src0_req_valid, src0_req_ready;
  logic [ADDR_W-1:0]      src0_req_addr;
  logic [SIZE_W-1:0]      src0_req_size;
  logic                   src1_req_valid, src1_req_ready;
  logic [ADDR_W-1:0]      src1_req_addr;
  logic [SIZE_W-1:0]      src1_req_size;
  logic                   dma_rd_req_vld, dma_rd_req_rdy;
  logic [SIZE_W+ADDR_W:0] dma_rd_req_pd;
  logic                   src0_rsp_done, src1_rsp_done;
  logic [7:0]             src0_outs_cnt, src1_outs_cnt;
  logic                   cnt_err;

  always #5 clk = ~clk;

  nv_nvdla_cdma_wt_dma_req_sel dut (
    .nvdla_core_clk (clk),
    .nvdla_core_rst (rst),
    .src0_req_valid (src0_req_valid),
    .src0_req_ready (src0_req_ready),
    .src0_req_addr  (src0_req_addr),
    .src0_req_size  (src0_req_size),
    .src1_req_valid (src1_req_valid),
    .src1_req_ready (src1_req_ready),
    .src1_req_addr  (src1_req_addr),
    .src1_req_size  (src1_req_size),
    .dma_rd_req_vld (dma_rd_req_vld),
    .dma_rd_req_rdy (dma_rd_req_rdy),
    .dma_rd_req_pd  (dma_rd_req_pd),
    .src0_rsp_done  (src0_rsp_done),
    .src1_rsp_done  (src1_rsp_done),
    .src0_outs_cnt  (src0_outs_cnt),
    .src1_outs_cnt  (src1_outs_cnt),
    .cnt_err        (cnt_err)
  );

  int n_vec = 0;
  int n_err = 0;

  // Reference model: pending request, outstanding counts, sticky error
  bit                     m_vld;
  logic [SIZE_W+ADDR_W:0] m_pd;
  int                     m_cnt [2];
  bit                     m_err;
  bit                     m_g0, m_g1;

  task automatic check(input string tag, input logic [95:0] act, input logic [95:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, act, exp, $time);
    end
  endtask

  function automatic bit pick(input int pct);
    return int'($urandom_range(99)) < pct;
  endfunction

  task automatic model_reset();
    m_vld    = 1'b0;
    m_pd     = '0;
    m_cnt[0] = 0;
    m_cnt[1] = 0;
    m_err    = 1'b0;
  endtask

  task automatic check_state(input string when);
    check({when, " vld"},  dma_rd_req_vld, m_vld);
    check({when, " pd"},   dma_rd_req_pd, m_pd);
    check({when, " cnt0"}, src0_outs_cnt, m_cnt[0]);
    check({when, " cnt1"}, src1_outs_cnt, m_cnt[1]);
    check({when, " err"},  cnt_err, m_err);
  endtask

  // One clock: percentages for valids, rdy and done; a done of 100 forces it even at count 0
  task automatic cycle(input int pv0, input int pv1, input int prdy, input int pd0,
                       input int pd1);
    bit done [2];
    @(negedge clk);
    src0_req_valid = pick(pv0);
    src1_req_valid = pick(pv1);
    src0_req_addr  = {$urandom, $urandom};
    src1_req_addr  = {$urandom, $urandom};
    src0_req_size  = SIZE_W'($urandom);
    src1_req_size  = SIZE_W'($urandom);
    dma_rd_req_rdy = pick(prdy);
    src0_rsp_done  = pick(pd0) && (m_cnt[0] > 0 || pd0 >= 100);
    src1_rsp_done  = pick(pd1) && (m_cnt[1] > 0 || pd1 >= 100);
    #1;
    // Who wins: nothing if the pending request is stuck, else first source with room
    m_g0 = 1'b0;
    m_g1 = 1'b0;
    if (!(m_vld && !dma_rd_req_rdy)) begin
      if (src0_req_valid && m_cnt[0] < MAX_OUTS)      m_g0 = 1'b1;
      else if (src1_req_valid && m_cnt[1] < MAX_OUTS) m_g1 = 1'b1;
    end
    check("src0_ready", src0_req_ready, m_g0);
    check("src1_ready", src1_req_ready, m_g1);
    @(posedge clk);
    if (m_g0)      begin m_vld = 1'b1; m_pd = {1'b0, src0_req_size, src0_req_addr}; end
    else if (m_g1) begin m_vld = 1'b1; m_pd = {1'b1, src1_req_size, src1_req_addr}; end
    else if (dma_rd_req_rdy) m_vld = 1'b0;
    done[0] = src0_rsp_done;
    done[1] = src1_rsp_done;
    m_cnt[0] = m_cnt[0] + int'(m_g0) - int'(done[0]);
    m_cnt[1] = m_cnt[1] + int'(m_g1) - int'(done[1]);
    for (int i = 0; i < 2; i++) begin
      if (m_cnt[i] < 0)        begin m_cnt[i] = 0;        m_err = 1'b1; end
      if (m_cnt[i] > MAX_OUTS) begin m_cnt[i] = MAX_OUTS; m_err = 1'b1; end
    end
    #1;
    check_state("post");
  endtask

  // Assert reset between edges with a pending, stalled request; release after one edge
  task automatic reset_mid();
    @(negedge clk);
    src0_req_valid = 1'b1;
    src1_req_valid = 1'b1;
    dma_rd_req_rdy = 1'b0;
    src0_rsp_done  = 1'b0;
    src1_rsp_done  = 1'b0;
    #2;
    rst = 1'b1;
    #1;
    model_reset();
    check_state("rst");
    check("rst src0_ready", src0_req_ready, 1'b0);
    check("rst src1_ready", src1_req_ready, 1'b0);
    @(posedge clk);
    #2;
    rst = 1'b0;
  endtask

  int max_cnt0;

  initial begin
    rst            = 1'b1;
    src0_req_valid = 1'b1;
    src1_req_valid = 1'b1;
    src0_req_addr  = '0;
    src1_req_addr  = '0;
    src0_req_size  = '0;
    src1_req_size  = '0;
    dma_rd_req_rdy = 1'b1;
    src0_rsp_done  = 1'b0;
    src1_rsp_done  = 1'b0;
    model_reset();
    #1;
    check_state("reset");
    check("reset src0_ready", src0_req_ready, 1'b0);
    check("reset src1_ready", src1_req_ready, 1'b0);
    @(posedge clk);
    #2;
    rst = 1'b0;

    // Both valid: source 0 first, then a 5-cycle stall, then release
    cycle(100, 100, 100, 0, 0);
    repeat (5) cycle(100, 100, 0, 0, 0);
    cycle(100, 100, 100, 0, 0);

    // Underflow on source 1 at count 0, error must stick
    cycle(0, 0, 100, 0, 100);
    repeat (20) cycle(50, 50, 70, 30, 30);
    reset_mid();

    repeat (300) cycle(60, 60, 70, 40, 40);

    // Drive source 0 to its in-flight limit so source 1 gets through
    max_cnt0 = 0;
    for (int i = 0; i < 300; i++) begin
      cycle(95, 70, 90, 0, 30);
      if (m_cnt[0] > max_cnt0) max_cnt0 = m_cnt[0];
    end
    check("src0 reached limit", max_cnt0, MAX_OUTS);
    cycle(100, 100, 100, 100, 0);
    cycle(100, 100, 100, 0, 0);

    repeat (300) cycle(60, 60, 70, 45, 45);
    reset_mid();
    repeat (200) cycle(70, 70, 60, 35, 35);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/nv_nvdla_cdma_wt_dma_req_sel.md
NV_NVDLA_CDMA_WT_DMA_REQ_SEL -- requirements
Module: NV_NVDLA_CDMA_WT_dma_req_sel

Interface
REQ-001 SHALL provide parameter ADDR_W, default 64, read address width.
REQ-002 SHALL provide parameter SIZE_W, default 15, request size width (size field holds beats-1).
REQ-003 SHALL provide parameter MAX_OUTS, default 128, maximum in-flight reads per source.
REQ-004 SHALL have one clock and an asynchronous active-high reset; clock and reset are the first two ports.
REQ-005 nvdla_core_clk  in  1  core clock.
REQ-006 nvdla_core_rst  in  1  async active-high reset.
REQ-007 src0_req_valid / src0_req_ready  in/out  1/1  weight-fetch request handshake.
REQ-008 src0_req_addr / src0_req_size  in  ADDR_W/SIZE_W  source 0 payload.
REQ-009 src1_req_valid / src1_req_ready  in/out  1/1  WMB-fetch request handshake.
REQ-010 src1_req_addr / src1_req_size  in  ADDR_W/SIZE_W  source 1 payload.
REQ-011 dma_rd_req_vld / dma_rd_req_rdy  out/in  1/1  DMA read request handshake.
REQ-012 dma_rd_req_pd  out  1+SIZE_W+ADDR_W  {src_id, size, addr}.
REQ-013 src0_rsp_done / src1_rsp_done  in  1/1  single-cycle pulse, one read retired.
REQ-014 src0_outs_cnt / src1_outs_cnt  out  8/8  in-flight read count.
REQ-015 cnt_err  out  1  sticky counter underflow/overflow flag.

Function
REQ-016 Source i SHALL be eligible when srci_req_valid=1 and srci_outs_cnt < MAX_OUTS.
REQ-017 Arbitration SHALL be strict priority, source 0 over source 1, combinational in the same cycle.
REQ-018 Arbiter busy SHALL equal dma_rd_req_vld & !dma_rd_req_rdy; no grant while busy.
REQ-019 srci_req_ready SHALL equal the grant for source i; at most one ready high per cycle.
REQ-020 On grant the output register SHALL load {src_id, size, addr} and set dma_rd_req_vld next cycle (latency 1).
REQ-021 Output stage SHALL accept a new grant in the same cycle its current request is taken (full throughput, 1 req/cycle).
REQ-022 dma_rd_req_vld SHALL clear after handshake when no grant occurs that cycle.
REQ-023 dma_rd_req_pd SHALL stay stable while dma_rd_req_vld=1 and dma_rd_req_rdy=0.
REQ-024 srci_outs_cnt SHALL increment on grant and decrement on srci_rsp_done; both in one cycle leaves it unchanged.
REQ-025 rsp_done with count 0 SHALL leave the count at 0 and set cnt_err.
REQ-026 An increment at MAX_OUTS cannot occur (eligibility); cnt_err SHALL also set if it would.
REQ-027 cnt_err SHALL remain set until reset.
REQ-028 Source 1 MAY starve indefinitely while source 0 is eligible; no fairness mechanism.

Reset
REQ-029 Reset SHALL clear dma_rd_req_vld, dma_rd_req_pd, both counters and cnt_err to 0 asynchronously.
REQ-030 srci_req_ready SHALL be 0 while reset is asserted.
REQ-031 Reset mid-operation SHALL discard the held request; no replay after release.
REQ-032 First grant SHALL be possible in the first clock edge after reset deassertion.

Structure
REQ-033 ADDR_W, SIZE_W, MAX_OUTS defaults and the pd field offsets SHALL live in a shared CDMA weight package.
REQ-034 Priority arbitration SHALL be a sub-module instance NV_NVDLA_CDMA_WT_sp_arb (req0, req1, gnt_busy -> gnt0, gnt1).
REQ-035 Counters and output register SHALL be in this module; no additional sub-modules.

Verification
REQ-036 Both valid, rdy=1, counts 0 -> src0_req_ready=1, src1 held; next cycle pd src_id=0, addr=src0_req_addr.
REQ-037 dma_rd_req_rdy=0 for 5 cycles with vld=1 -> both ready=0, pd unchanged; rdy=1 -> new grant same cycle.
REQ-038 src0_outs_cnt=128, both valid -> src1 granted; one src0_rsp_done -> count 127, src0 granted next eligible cycle.
REQ-039 Grant and rsp_done same cycle for src1 at count 5 -> count stays 5.
REQ-040 src1_rsp_done at count 0 -> count 0, cnt_err=1 until reset.
REQ-041 Reset asserted with vld=1 -> vld=0, counts 0 immediately; no replay after release.
